aes_encipher_param: RTL and testbench

AES_ENCIPHER_PARAM -- requirements
Module: aes_encipher_param

---
 rtl/aes_encipher_param.sv | 165 ++++++++++++++++
 tb/tb_aes_encipher_param.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_encipher_param.sv
// Iterative AES encipher, one round per clock, using pre-expanded round keys held in a local store.
// Nr is latched from keylen on accept; DONE can accept the next block on the same edge it hands off.
module aes_encipher_param #(
  parameter int unsigned NR_MAX = 14,
  parameter int unsigned RK_AW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       keylen,
  input  logic             rk_we,
  input  logic [RK_AW-1:0] rk_addr,
  input  logic [127:0]     rk_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_block,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, KEYADD, ROUND, DONE} state_e;

  localparam logic [RK_AW-1:0] NR_MAX_A = RK_AW'(NR_MAX);
  localparam logic [RK_AW-1:0] NR128    = RK_AW'(10);
  // Key lengths whose Nr does not fit the key store fall back to AES-128.
  localparam logic [RK_AW-1:0] NR192    = (NR_MAX >= 12) ? RK_AW'(12) : NR128;
  localparam logic [RK_AW-1:0] NR256    = (NR_MAX >= 14) ? RK_AW'(14) : NR128;

  if (NR_MAX < 10 || NR_MAX >= (1 << RK_AW)) begin : g_bad_params
    $error("aes_encipher_param: NR_MAX must be >= 10 and addressable with RK_AW bits");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++) o[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
    return o;
  endfunction

  // Byte r+4c is row r, column c; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [RK_AW-1:0] nr_of(input logic [1:0] kl);
    logic [RK_AW-1:0] nr;
    case (kl)
      2'b01:   nr = NR192;
      2'b10:   nr = NR256;
      default: nr = NR128;
    endcase
    return nr;
  endfunction

  state_e           st_q, st_d;
  logic [RK_AW-1:0] round_q, round_d;
  logic [RK_AW-1:0] nr_q, nr_d;
  logic [127:0]     blk_q, blk_d;
  logic [127:0]     rk_q [0:NR_MAX];
  logic [127:0]     sr, mc, rkey;
  logic             accept;

  assign out_valid = (st_q == DONE);
  assign busy      = (st_q == KEYADD) || (st_q == ROUND);
  assign in_ready  = (st_q == IDLE) || ((st_q == DONE) && out_ready);
  assign out_block = blk_q;
  assign accept    = in_valid && in_ready;

  assign sr   = shift_rows(sub_bytes(blk_q));
  assign mc   = mix_columns(sr);
  assign rkey = rk_q[round_q];

  always_comb begin
    st_d    = st_q;
    round_d = round_q;
    nr_d    = nr_q;
    blk_d   = blk_q;
    case (st_q)
      KEYADD: begin
        blk_d   = blk_q ^ rk_q[0];
        round_d = RK_AW'(1);
        st_d    = ROUND;
      end
      ROUND: begin
        if (round_q == nr_q) begin
          blk_d = sr ^ rkey;
          st_d  = DONE;
        end else begin
          blk_d   = mc ^ rkey;
          round_d = round_q + 1'b1;
        end
      end
      DONE:    if (out_ready && !in_valid) st_d = IDLE;
      default: ;
    endcase
    // Accept overrides the DONE hand-off so back-to-back blocks have no bubble.
    if (accept) begin
      blk_d   = in_block;
      nr_d    = nr_of(keylen);
      round_d = '0;
      st_d    = KEYADD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= IDLE;
      round_q <= '0;
      nr_q    <= NR128;
      blk_q   <= '0;
    end else begin
      st_q    <= st_d;
      round_q <= round_d;
      nr_q    <= nr_d;
      blk_q   <= blk_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i <= NR_MAX; i++) rk_q[i] <= '0;
    end else if (rk_we && !busy && (rk_addr <= NR_MAX_A)) begin
      rk_q[rk_addr] <= rk_data;
    end
  end

endmodule

// File: tb/tb_aes_encipher_param.sv
// Directed bench for aes_encipher_param: FIPS-197 vectors with round keys expanded here,
// plus backpressure, dropped-write, keylen-change and mid-block reset sequences.
module tb_aes_encipher_param;

  logic         clk, rst;
  logic [1:0]   keylen;
  logic         rk_we;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;
  logic         in_valid, in_ready;
  logic [127:0] in_block;
  logic         out_valid, out_ready;
  logic [127:0] out_block;
  logic         busy;

  aes_encipher_param #(.NR_MAX(14), .RK_AW(4)) dut (
    .clk(clk), .rst(rst), .keylen(keylen), .rk_we(rk_we), .rk_addr(rk_addr),
    .rk_data(rk_data), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   sbm [256];
  logic [127:0] rk_tbl [0:14];

  localparam logic [255:0] K128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KFIP = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  typedef struct {
    logic [1:0]   kl;
    logic [1:0]   ek;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    int           lat;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse, then the affine map.
  task automatic build_sbox();
    logic [7:0] inv, r, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ 8'h63;
      r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      sbm[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbm[w[31:24]], sbm[w[23:16]], sbm[w[15:8]], sbm[w[7:0]]};
  endfunction

  task automatic expand(input logic [1:0] ek, input logic [255:0] key, output int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    case (ek)
      2'd1:    begin nk = 6; nr = 12; end
      2'd2:    begin nk = 8; nr = 14; end
      default: begin nk = 4; nr = 10; end
    endcase
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_tbl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_keys(input logic [1:0] ek, input logic [255:0] key);
    int nr;
    expand(ek, key, nr);
    for (int r = 0; r <= nr; r++) begin
      rk_we = 1'b1; rk_addr = 4'(r); rk_data = rk_tbl[r];
      @(posedge clk); #1;
    end
    rk_we = 1'b0;
  endtask

  // Offers one block, then counts edges after the accept edge until out_valid (bounded).
  // wr_at >= 0 drives a corrupt write to rk[5] at that cycle; keylen is scrambled after accept.
  task automatic run_block(input logic [1:0] kl, input logic [127:0] pt, input int wr_at,
                           output logic [127:0] ct, output int lat,
                           output logic mid_busy, output logic mid_rdy);
    keylen = kl; in_block = pt; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_block = ~pt; keylen = ~kl;
    lat = 0; mid_busy = 1'b0; mid_rdy = 1'b1;
    while (!out_valid && lat < 40) begin
      if (lat == 3) begin mid_busy = busy; mid_rdy = in_ready; end
      if (lat == wr_at) begin rk_we = 1'b1; rk_addr = 4'd5; rk_data = '1; end
      else rk_we = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    rk_we = 1'b0;
    ct = out_block;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ct;
    int           lat;
    logic         mb, mr, seen;

    rst = 1'b0; keylen = 2'd0; rk_we = 1'b0; rk_addr = '0; rk_data = '0;
    in_valid = 1'b0; in_block = '0; out_ready = 1'b1;
    build_sbox();

    vecs[0] = '{kl: 2'd0, ek: 2'd0, key: K128, pt: PT, ct: CT128, lat: 11};
    vecs[1] = '{kl: 2'd1, ek: 2'd1, key: K192, pt: PT,
                ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191, lat: 13};
    vecs[2] = '{kl: 2'd2, ek: 2'd2, key: K256, pt: PT,
                ct: 128'h8ea2b7ca516745bfeafc49904b496089, lat: 15};
    vecs[3] = '{kl: 2'd3, ek: 2'd0, key: K128, pt: PT, ct: CT128, lat: 11};
    vecs[4] = '{kl: 2'd0, ek: 2'd0, key: KFIP, pt: 128'h3243f6a8885a308d313198a2e0370734,
                ct: 128'h3925841d02dc09fbdc118597196a0b32, lat: 11};

    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_busy",      128'(busy),      128'd0);
    check("reset_in_ready",  128'(in_ready),  128'd1);
    check("reset_out_block", out_block,       128'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      load_keys(vecs[i].ek, vecs[i].key);
      run_block(vecs[i].kl, vecs[i].pt, -1, ct, lat, mb, mr);
      check($sformatf("vec%0d_latency", i),  128'(lat), 128'(vecs[i].lat));
      check($sformatf("vec%0d_ct", i),       ct,        vecs[i].ct);
      check($sformatf("vec%0d_mid_busy", i), 128'(mb),  128'd1);
      check($sformatf("vec%0d_mid_ready", i), 128'(mr), 128'd0);
    end

    // Backpressure, then zero-bubble accept from DONE.
    load_keys(2'd0, K128);
    out_ready = 1'b0;
    run_block(2'd0, PT, -1, ct, lat, mb, mr);
    check("bp_ct", ct, CT128);
    check("bp_latency", 128'(lat), 128'd11);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold_valid_c%0d", c), 128'(out_valid), 128'd1);
      check($sformatf("bp_hold_block_c%0d", c), out_block,       CT128);
      check($sformatf("bp_hold_ready_c%0d", c), 128'(in_ready),  128'd0);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_block = PT;
    #1;
    check("bp_release_ready", 128'(in_ready), 128'd1);
    run_block(2'd0, PT, -1, ct, lat, mb, mr);
    check("b2b_latency", 128'(lat), 128'd11);
    check("b2b_ct", ct, CT128);
    check("b2b_mid_busy", 128'(mb), 128'd1);

    // Write to rk[5] while busy must be dropped; keylen is changed after accept.
    run_block(2'd0, PT, 2, ct, lat, mb, mr);
    check("drop_wr_latency", 128'(lat), 128'd11);
    check("drop_wr_ct", ct, CT128);
    run_block(2'd0, PT, -1, ct, lat, mb, mr);
    check("after_drop_ct", ct, CT128);

    // Reset in the middle of round 6 aborts the block.
    @(posedge clk); #1;
    keylen = 2'd0; in_block = PT; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_busy", 128'(busy), 128'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_busy",      128'(busy),      128'd0);
    check("rst_in_ready",  128'(in_ready),  128'd1);
    check("rst_out_block", out_block,       128'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (16) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst_no_output", 128'(seen), 128'd0);
    load_keys(2'd0, K128);
    run_block(2'd0, PT, -1, ct, lat, mb, mr);
    check("post_rst_latency", 128'(lat), 128'd11);
    check("post_rst_ct", ct, CT128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
